// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between instruction fetch and
//   the stage-2 load/store path. Data wins contention unless fetch has
//   already lost STARVE_MAX grants in a row. A tag shift register follows
//   each issued read so that its data is returned to the port that asked for
//   it. Each port keeps its last read data between returns.
//
// Ports
//   clk, rst               clock, async active-high reset
//   if_req/if_addr         fetch request (read only)
//   if_gnt/if_rvalid/if_rdata   fetch grant, return valid, return data
//   d_req/d_we/d_addr/d_wdata   data request (d_we == 0 means read)
//   d_gnt/d_rvalid/d_rdata      data grant, return valid, return data
//   mem_en/mem_we/mem_addr/mem_din/mem_dout   memory port
//   stall                  some requester is waiting this cycle
module mem_port_arbiter #(
  parameter int AWIDTH     = 14,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic              stall
);

  localparam int SCW = $clog2(STARVE_MAX + 1);

  logic [SCW-1:0]  sc;        // consecutive data grants while fetch waits
  logic            starved;
  logic            rd_issue;
  logic [RD_LAT:1] vld_pipe;  // read tag valid, stage RD_LAT is the return
  logic [RD_LAT:1] own_pipe;  // read tag owner, 1 = data port
  logic [31:0]     hold_if;
  logic [31:0]     hold_d;

  // ---- grant -------------------------------------------------------------
  // A sole requester never sees 'starved', so it is always granted.
  assign starved = if_req & (sc == SCW'(STARVE_MAX));
  assign d_gnt   = d_req & ~starved;
  assign if_gnt  = if_req & ~d_gnt;

  // ---- memory port -------------------------------------------------------
  assign mem_en   = if_gnt | d_gnt;
  assign mem_addr = d_gnt ? d_addr : if_addr;
  assign mem_din  = d_gnt ? d_wdata : 32'h0;
  assign mem_we   = d_gnt ? d_we : 4'b0;

  assign stall = (if_req & ~if_gnt) | (d_req & ~d_gnt);

  // ---- starvation counter ------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sc <= '0;
    else if (if_gnt || !if_req)
      sc <= '0;
    else if (d_gnt && sc != SCW'(STARVE_MAX))
      sc <= sc + SCW'(1);
  end

  // ---- read tag pipeline -------------------------------------------------
  // Writes and idle cycles shift in an invalid tag.
  assign rd_issue = if_gnt | (d_gnt & (d_we == 4'b0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[1] <= 1'b0;
      own_pipe[1] <= 1'b0;
    end else begin
      vld_pipe[1] <= rd_issue;
      own_pipe[1] <= d_gnt;
    end
  end

  for (genvar i = 2; i <= RD_LAT; i++) begin : g_tag
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_pipe[i] <= 1'b0;
        own_pipe[i] <= 1'b0;
      end else begin
        vld_pipe[i] <= vld_pipe[i-1];
        own_pipe[i] <= own_pipe[i-1];
      end
    end
  end

  assign if_rvalid = vld_pipe[RD_LAT] & ~own_pipe[RD_LAT];
  assign d_rvalid  = vld_pipe[RD_LAT] &  own_pipe[RD_LAT];

  // ---- read data hold ----------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_if <= 32'h0;
      hold_d  <= 32'h0;
    end else begin
      if (if_rvalid) hold_if <= mem_dout;
      if (d_rvalid)  hold_d  <= mem_dout;
    end
  end

  assign if_rdata = if_rvalid ? mem_dout : hold_if;
  assign d_rdata  = d_rvalid  ? mem_dout : hold_d;

endmodule
